// File: rtl/fifo_wptr_full_pkg.sv
// fifo_wptr_full_pkg: shared async-FIFO constants and pointer encoding helpers
package fifo_wptr_full_pkg;
  localparam int FIFO_ADDRSIZE = 4;
  localparam int FIFO_DEPTH = 1 << FIFO_ADDRSIZE;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray-to-binary conversion as a prefix XOR from the MSB
module fifo_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end
endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side pointer, full/almost-full/level and sticky overflow of the async FIFO
module fifo_wptr_full
  import fifo_wptr_full_pkg::*;
#(
  parameter int ADDRSIZE = FIFO_ADDRSIZE,
  parameter int AFULL_LVL = 12
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic                wovf_clr,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);
  logic [ADDRSIZE:0] wbin, wbinnext, wgraynext, rbin, wlevelnext;
  logic wfullnext;
  assign wen = winc & ~wfull;
  assign waddr = wbin[ADDRSIZE-1:0];
  assign wbinnext = wbin + (ADDRSIZE+1)'(wen);
  assign wgraynext = (ADDRSIZE+1)'(bin2gray(32'(wbinnext)));
  fifo_gray2bin #(.WIDTH(ADDRSIZE+1)) u_rptr_bin (
    .gray(wq2_rptr),
    .bin (rbin)
  );
  assign wlevelnext = wbinnext - rbin;
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted, rest equal.
  assign wfullnext = wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin <= '0;
      wptr <= '0;
      wfull <= 1'b0;
      walmost_full <= 1'b0;
      wlevel <= '0;
      wovf <= 1'b0;
    end else begin
      wbin <= wbinnext;
      wptr <= wgraynext;
      wfull <= wfullnext;
      walmost_full <= wlevelnext >= (ADDRSIZE+1)'(AFULL_LVL);
      wlevel <= wlevelnext;
      wovf <= (winc & wfull) | (wovf & ~wovf_clr);
    end
  end
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: vector table plus model-driven scoreboard for the FIFO write-side stage
module tb_fifo_wptr_full;
  typedef struct {
    logic rst, inc, clr;
    logic [4:0] rg;
    logic en;
    logic [3:0] addr;
    logic [4:0] ptr;
    logic full, af;
    logic [4:0] lvl;
    logic ovf;
  } vec_t;

  logic wclk = 0, wrst = 0, winc = 0, wovf_clr = 0;
  logic [4:0] wq2_rptr = 0;
  logic wen, wfull, walmost_full, wovf;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;
  int pass_cnt = 0, total_cnt = 0;
  vec_t tbl[$];
  vec_t exp_q[$];
  int mw = 0, movf = 0, mfull = 0;

  fifo_wptr_full #(.ADDRSIZE(4), .AFULL_LVL(12)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr), .wq2_rptr(wq2_rptr),
    .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .wlevel(wlevel), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gr(input int b);
    logic [4:0] x;
    x = 5'(b);
    return x ^ (x >> 1);
  endfunction

  function automatic vec_t mk(input logic rst, inc, clr, input logic [4:0] rg, input logic en,
                              input int addr, ptr, input logic full, af, input int lvl, input logic ovf);
    vec_t v;
    v.rst = rst; v.inc = inc; v.clr = clr; v.rg = rg; v.en = en;
    v.addr = 4'(addr); v.ptr = 5'(ptr); v.full = full; v.af = af; v.lvl = 5'(lvl); v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    wrst = v.rst; winc = v.inc; wovf_clr = v.clr; wq2_rptr = v.rg;
    #1;
    if (!v.rst) chk("wen", int'(wen), int'(v.en));
    exp_q.push_back(v);
    @(posedge wclk);
    #1;
    e = exp_q.pop_front();
    chk("waddr", int'(waddr), int'(e.addr));
    chk("wptr", int'(wptr), int'(e.ptr));
    chk("wfull", int'(wfull), int'(e.full));
    chk("walmost_full", int'(walmost_full), int'(e.af));
    chk("wlevel", int'(wlevel), int'(e.lvl));
    chk("wovf", int'(wovf), int'(e.ovf));
  endtask

  // Reference model: counts writes independently and derives level/full from counts.
  task automatic mstep(input logic rst, inc, clr, input int rc);
    vec_t v;
    int lvl;
    v.rst = rst; v.inc = inc; v.clr = clr; v.rg = gr(rc % 32);
    v.en = inc && mfull == 0;
    if (rst) begin
      mw = 0; mfull = 0; movf = 0; lvl = 0;
    end else begin
      if (inc && mfull != 0) movf = 1;
      else if (clr) movf = 0;
      if (v.en) mw = (mw + 1) % 32;
      lvl = (mw - rc % 32 + 32) % 32;
      mfull = int'(lvl == 16);
    end
    v.addr = 4'(mw % 16); v.ptr = gr(mw); v.full = mfull != 0;
    v.af = !rst && lvl >= 12; v.lvl = 5'(lvl); v.ovf = movf != 0;
    apply(v);
  endtask

  initial begin
    int wc_hist[$];
    int wraps;
    logic [4:0] prev_ptr;
    logic [3:0] prev_addr;
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 16; i++)
      tbl.push_back(mk(0, 1, 0, 0, 1, i % 16, gr(i), i == 16, i >= 12, i, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5'b11000, 1, 1, 16, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b11000, 1, 1, 16, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 5'b11000, 1, 1, 16, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 5'b11000, 1, 1, 16, 0));
    tbl.push_back(mk(0, 0, 0, 5'b00001, 0, 0, 5'b11000, 0, 1, 15, 0));
    tbl.push_back(mk(0, 0, 0, gr(2), 0, 0, 5'b11000, 0, 1, 14, 0));
    tbl.push_back(mk(0, 0, 0, gr(3), 0, 0, 5'b11000, 0, 1, 13, 0));
    tbl.push_back(mk(0, 0, 0, gr(4), 0, 0, 5'b11000, 0, 1, 12, 0));
    tbl.push_back(mk(0, 0, 0, gr(5), 0, 0, 5'b11000, 0, 0, 11, 0));
    tbl.push_back(mk(0, 1, 0, gr(5), 1, 1, gr(17), 0, 1, 12, 0));
    @(posedge wclk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // Wrap: 40 writes with the read pointer trailing two cycles behind.
    mstep(1, 0, 0, 0);
    wc_hist = '{0, 0};
    wraps = 0;
    for (int i = 0; i < 40; i++) begin
      prev_ptr = wptr;
      prev_addr = waddr;
      mstep(0, 1, 0, wc_hist.pop_front());
      wc_hist.push_back(mw);
      chk("wptr_hamming", $countones(prev_ptr ^ wptr), 1);
      if (prev_addr == 4'd15 && waddr == 4'd0) wraps++;
    end
    chk("waddr_wraps", wraps, 2);

    // Mid-operation reset after 7 writes, then the next write lands at address 0.
    mstep(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) mstep(0, 1, 0, 0);
    mstep(1, 1, 1, 0);
    chk("waddr_after_rst", int'(waddr), 0);
    mstep(0, 1, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
